mem_responder: RTL

Data-memory responder for the processor's load/store path. It accepts one word or byte access per handshake, holds it for a fixed number of wait states, and then returns read data or a write acknowledgement. Out-of-range and misaligned accesses complete with an error and leave memory unchanged. It sits between the datapath's memory port (address from ALU result, store data from the register file) and the on-chip data array, and lets the control FSM stall on memory the same way it stalls on other multi-cycle operations.

---
 rtl/mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Data-memory responder: one load/store per handshake, fixed wait states,
// error completion for out-of-range or misaligned accesses.
module mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_WrEn,
    input  logic        Req_Size,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_WrData,
    output logic        Rsp_Valid,
    input  logic        Rsp_Ready,
    output logic [31:0] Rsp_Data,
    output logic        Rsp_Err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = BASE_ADDR + 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT state;
    stateT nextState;

    logic          capWrEn;
    logic          capSize;
    logic [31:0]   capAddr;
    logic [31:0]   capWrData;
    logic [3:0]    count;

    logic          idle;
    logic          accept;
    logic          enterResp;
    logic          memWrite;
    logic          curWrEn;
    logic          curSize;
    logic [31:0]   curAddr;
    logic [31:0]   curWrData;
    logic          curErr;
    logic [31:0]   offset;
    logic [AW-1:0] wordIdx;
    logic [1:0]    lane;
    logic [31:0]   rdWord;
    logic [31:0]   loadData;
    logic          unusedOffset;

    logic [31:0] mem [DEPTH_WORDS];

    // Error/range decode sees the live request in IDLE so error and
    // zero-latency responses can be formed on the accepting edge itself.
    always_comb begin
        idle      = (state == IDLE);
        curWrEn   = idle ? Req_WrEn   : capWrEn;
        curSize   = idle ? Req_Size   : capSize;
        curAddr   = idle ? Req_Addr   : capAddr;
        curWrData = idle ? Req_WrData : capWrData;
        offset    = curAddr - BASE_ADDR;
        curErr    = (curAddr < BASE_ADDR) || (curAddr >= LIMIT) ||
                    (curSize && (curAddr[1:0] != 2'b00));
        wordIdx   = offset[AW+1:2];
        lane      = curAddr[1:0];
        rdWord    = mem[wordIdx];
        loadData  = curSize ? rdWord : {24'h0, rdWord[{lane, 3'b000} +: 8]};
        unusedOffset = ^{offset[31:AW+2], offset[1:0]};
    end

    assign accept    = Req_Valid && idle;
    assign enterResp = (nextState == RESP) && (state != RESP);
    assign memWrite  = enterResp && curWrEn && !curErr && !Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (curErr || LATENCY == 0) nextState = RESP;
                    else                        nextState = WAIT;
                end
            end
            WAIT: if (count == 4'd1) nextState = RESP;
            RESP: if (Rsp_Ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        Req_Ready = (state == IDLE);
        Rsp_Valid = (state == RESP);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            capWrEn   <= 1'b0;
            capSize   <= 1'b0;
            capAddr   <= '0;
            capWrData <= '0;
            count     <= '0;
            Rsp_Data  <= '0;
            Rsp_Err   <= 1'b0;
        end else begin
            if (accept) begin
                capWrEn   <= Req_WrEn;
                capSize   <= Req_Size;
                capAddr   <= Req_Addr;
                capWrData <= Req_WrData;
            end
            if (idle && nextState == WAIT) count <= 4'(LATENCY);
            else if (state == WAIT)        count <= count - 4'd1;
            if (enterResp) begin
                Rsp_Err  <= curErr;
                Rsp_Data <= (curErr || curWrEn) ? 32'h0 : loadData;
            end else if (state == RESP && Rsp_Ready) begin
                Rsp_Err  <= 1'b0;
                Rsp_Data <= '0;
            end
        end
    end

    // The array has no reset; a byte store touches only its own lane.
    always_ff @(posedge Clk) begin
        if (memWrite) begin
            if (curSize) mem[wordIdx] <= curWrData;
            else         mem[wordIdx][{lane, 3'b000} +: 8] <= curWrData[7:0];
        end
    end

endmodule
